// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response encodings for the local-register bridge.
// Optional feature macro used by the bridge: AXIL_BRIDGE_TIMEOUT_EN.
package axil_pkg;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_SLVERR = 2'b10;

    function automatic axil_resp_t err_resp(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_sync_fifo.sv
// Small synchronous FIFO with extra-bit pointers; no bypass of the
// push data, so the head is only visible the cycle after the push.
module axil_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) &&
                     (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/axil_slave_bridge.sv
// AXI4-Lite slave to local req/ack register port with AW/W/AR request FIFOs.
// Define AXIL_BRIDGE_TIMEOUT_EN to let a stalled local request self-complete with SLVERR.
module axil_slave_bridge
    import axil_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 2,
    parameter int TIMEOUT_CYC = 256,
    localparam int STRB_W     = DATA_W / 8
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0] s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [STRB_W-1:0] wr_strb,
    input  logic              wr_ack,
    input  logic              wr_err,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_ack,
    input  logic              rd_err
);

    logic aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
    logic wr_to, rd_to, wr_done, rd_done;
    logic [STRB_W+DATA_W-1:0] w_head;

    assign s_axi_awready = s_axi_aresetn & ~aw_full;
    assign s_axi_wready  = s_axi_aresetn & ~w_full;
    assign s_axi_arready = s_axi_aresetn & ~ar_full;

    assign wr_req  = ~aw_empty & ~w_empty & ~s_axi_bvalid;
    assign rd_req  = ~ar_empty & ~s_axi_rvalid;
    assign wr_done = wr_req & (wr_ack | wr_to);
    assign rd_done = rd_req & (rd_ack | rd_to);
    assign {wr_strb, wr_data} = w_head;

    axil_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .push  (s_axi_awvalid & s_axi_awready),
        .din   (s_axi_awaddr),
        .pop   (wr_done),
        .full  (aw_full),
        .empty (aw_empty),
        .head  (wr_addr)
    );

    axil_sync_fifo #(.WIDTH(STRB_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_w_fifo (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .push  (s_axi_wvalid & s_axi_wready),
        .din   ({s_axi_wstrb, s_axi_wdata}),
        .pop   (wr_done),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    axil_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .push  (s_axi_arvalid & s_axi_arready),
        .din   (s_axi_araddr),
        .pop   (rd_done),
        .full  (ar_full),
        .empty (ar_empty),
        .head  (rd_addr)
    );

`ifdef AXIL_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;

    // A same-cycle ack beats the timeout so the core's own status is used
    assign wr_to = wr_req & ~wr_ack & (wr_cnt == CNT_LAST);
    assign rd_to = rd_req & ~rd_ack & (rd_cnt == CNT_LAST);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            wr_cnt <= (!wr_req || wr_done) ? '0 : wr_cnt + 1'b1;
            rd_cnt <= (!rd_req || rd_done) ? '0 : rd_cnt + 1'b1;
        end
    end
`else
    assign wr_to = 1'b0;
    assign rd_to = 1'b0;
`endif

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else if (wr_done) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_ack ? err_resp(wr_err) : RESP_SLVERR;
        end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
        end else if (rd_done) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rresp  <= rd_ack ? err_resp(rd_err) : RESP_SLVERR;
            s_axi_rdata  <= rd_ack ? rd_data : '0;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_slave_bridge.sv
// Directed + randomized check of axil_slave_bridge against a queue-based
// transaction model (FIFO_DEPTH=2, TIMEOUT_CYC=8).
module tb_axil_slave_bridge;
    import axil_pkg::*;

    localparam int AW = 5, DW = 32, SW = 4, DEPTH = 2, TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] awaddr, araddr, wr_addr, rd_addr;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata, wr_data, rd_data;
    logic [SW-1:0] wstrb, wr_strb;
    logic [1:0] bresp, rresp;
    logic wr_req, wr_ack, wr_err, rd_req, rd_ack, rd_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axil_slave_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_ack(rd_ack), .rd_err(rd_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // transaction model
    logic [AW-1:0]    awq[$];
    logic [SW+DW-1:0] wq[$];
    logic [AW-1:0]    arq[$];
    logic [1:0]       bq[$];
    logic [DW+1:0]    rq[$];

    initial begin
        int n, g, seen, ai, bi;
        logic [AW-1:0] exp_a[2];
        logic [1:0]    exp_b[3];
        bit aw_f, w_f, ar_f, b_f, r_f, wk, rk;
        int wrun, rrun;

        rst_n = 1'b0;
        {awaddr, awvalid, wdata, wstrb, wvalid, bready} = '0;
        {araddr, arvalid, rready} = '0;
        {wr_ack, wr_err, rd_data, rd_ack, rd_err} = '0;

        // reset state
        #12;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bresp", bresp, RESP_OKAY);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_rd_req", rd_req, 0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #3; rst_n = 1'b1;
        tick;
        chk("idle_awready", awready, 1);

        // single write, minimum latency
        awvalid = 1; awaddr = 5'h04; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick;
        awvalid = 0; wvalid = 0;
        chk("t1_wr_req", wr_req, 1);
        chk("t1_wr_addr", wr_addr, 5'h04);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        chk("t1_wr_strb", wr_strb, 4'hF);
        wr_ack = 1; wr_err = 0;
        tick;
        wr_ack = 0;
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, RESP_OKAY);
        chk("t1_req_drop", wr_req, 0);
        bready = 1;
        tick;
        bready = 0;
        chk("t1_bclear", bvalid, 0);

        // read with error
        arvalid = 1; araddr = 5'h10;
        tick;
        arvalid = 0;
        chk("t3_rd_req", rd_req, 1);
        chk("t3_rd_addr", rd_addr, 5'h10);
        rd_ack = 1; rd_err = 1; rd_data = 32'h1234;
        tick;
        rd_ack = 0; rd_err = 0;
        chk("t3_rvalid", rvalid, 1);
        chk("t3_rresp", rresp, RESP_SLVERR);
        chk("t3_rdata", rdata, 32'h1234);
        chk("t3_rd_req_drop", rd_req, 0);
        tick;
        chk("t3_rhold", rdata, 32'h1234);
        rready = 1;
        tick;
        rready = 0;
        chk("t3_rclear", rvalid, 0);

        // W ahead of AW
        wvalid = 1; wdata = 32'hA5A5_0F0F; wstrb = 4'h3;
        tick;
        wvalid = 0;
        chk("t4_no_req0", wr_req, 0);
        tick;
        chk("t4_no_req1", wr_req, 0);
        awvalid = 1; awaddr = 5'h08;
        tick;
        awvalid = 0;
        chk("t4_wr_req", wr_req, 1);
        chk("t4_wr_addr", wr_addr, 5'h08);
        chk("t4_wr_data", wr_data, 32'hA5A5_0F0F);
        chk("t4_wr_strb", wr_strb, 4'h3);
        wr_ack = 1;
        tick;
        wr_ack = 0; bready = 1;
        tick;
        bready = 0;

        // backpressure: three writes with bready low
        awvalid = 1; wvalid = 1;
        awaddr = 5'h01; wdata = 32'h1111_1111; wstrb = 4'h1;
        tick;
        awaddr = 5'h02; wdata = 32'h2222_2222; wstrb = 4'h2;
        tick;
        awaddr = 5'h03; wdata = 32'h3333_3333; wstrb = 4'h4;
        chk("t2_awready_full", awready, 0);
        chk("t2_wready_full", wready, 0);
        chk("t2_head", wr_addr, 5'h01);
        wr_ack = 1; wr_err = 0;
        tick;
        wr_ack = 0;
        chk("t2_bvalid", bvalid, 1);
        chk("t2_awready_free", awready, 1);
        tick;
        awvalid = 0; wvalid = 0;
        chk("t2_bresp_hold", bresp, RESP_OKAY);
        chk("t2_req_blocked", wr_req, 0);
        exp_a[0] = 5'h02; exp_a[1] = 5'h03;
        exp_b[0] = RESP_OKAY; exp_b[1] = RESP_SLVERR; exp_b[2] = RESP_OKAY;
        ai = 0; bi = 0; g = 0;
        while (bi < 3 && g < 40) begin
            bready = 1;
            wr_ack = wr_req;
            wr_err = (wr_addr == 5'h02);
            if (bvalid) begin
                chk("t2_bresp_order", bresp, exp_b[bi]);
                bi++;
            end
            if (wr_req && ai < 2) begin
                chk("t2_addr_order", wr_addr, exp_a[ai]);
                ai++;
            end
            tick;
            g++;
        end
        chk("t2_drained", bi, 3);
        wr_ack = 0; wr_err = 0; bready = 0;
        tick;

        // local timeout
        arvalid = 1; araddr = 5'h03;
        tick;
        arvalid = 0;
`ifdef AXIL_BRIDGE_TIMEOUT_EN
        n = 0; g = 0;
        while (!rvalid && g < 40) begin
            if (rd_req) n++;
            tick;
            g++;
        end
        chk("t5_to_cycles", n, TO);
        chk("t5_rvalid", rvalid, 1);
        chk("t5_rresp", rresp, RESP_SLVERR);
        chk("t5_rdata", rdata, 0);
`else
        seen = 0;
        repeat (20) begin
            if (rvalid) seen++;
            tick;
        end
        chk("t5_no_rvalid", seen, 0);
        chk("t5_req_held", rd_req, 1);
        rd_ack = 1; rd_data = 32'h55;
        tick;
        rd_ack = 0;
`endif
        rready = 1;
        tick;
        rready = 0;

        // reset mid-transaction
        awvalid = 1; wvalid = 1; awaddr = 5'h06; wdata = 32'h6;
        tick;
        awaddr = 5'h07; wdata = 32'h7; wr_ack = 1;
        tick;
        awvalid = 0; wvalid = 0; wr_ack = 0;
        arvalid = 1; araddr = 5'h09;
        tick;
        arvalid = 0;
        chk("t6_pre_bvalid", bvalid, 1);
        chk("t6_pre_rd_req", rd_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_bvalid", bvalid, 0);
        chk("t6_rvalid", rvalid, 0);
        chk("t6_wr_req", wr_req, 0);
        chk("t6_rd_req", rd_req, 0);
        chk("t6_awready", awready, 0);
        chk("t6_arready", arready, 0);
        @(posedge clk); #3; rst_n = 1'b1;
        tick;
        chk("t6_post_awready", awready, 1);
        chk("t6_post_wready", wready, 1);
        chk("t6_post_wr_req", wr_req, 0);
        chk("t6_post_bvalid", bvalid, 0);

        // randomized traffic against the queue model
        wrun = 0; rrun = 0;
        repeat (3000) begin
            chk("r_awready", awready, awq.size() < DEPTH);
            chk("r_wready", wready, wq.size() < DEPTH);
            chk("r_arready", arready, arq.size() < DEPTH);
            chk("r_wr_req", wr_req, awq.size() > 0 && wq.size() > 0 && bq.size() == 0);
            chk("r_rd_req", rd_req, arq.size() > 0 && rq.size() == 0);
            chk("r_bvalid", bvalid, bq.size() != 0);
            chk("r_rvalid", rvalid, rq.size() != 0);
            if (wr_req && awq.size() > 0 && wq.size() > 0) begin
                chk("r_wr_addr", wr_addr, awq[0]);
                chk("r_wr_wd", {wr_strb, wr_data}, wq[0]);
            end
            if (rd_req && arq.size() > 0) chk("r_rd_addr", rd_addr, arq[0]);
            if (bvalid && bq.size() > 0) chk("r_bresp", bresp, bq[0]);
            if (rvalid && rq.size() > 0) chk("r_rdata_resp", {rdata, rresp}, rq[0]);

            if (!awvalid && $urandom_range(0, 2) == 0) begin
                awvalid = 1; awaddr = AW'($urandom);
            end
            if (!wvalid && $urandom_range(0, 2) == 0) begin
                wvalid = 1; wdata = $urandom; wstrb = SW'($urandom);
            end
            if (!arvalid && $urandom_range(0, 2) == 0) begin
                arvalid = 1; araddr = AW'($urandom);
            end
            bready = ($urandom_range(0, 9) < 6);
            rready = ($urandom_range(0, 9) < 6);
            wr_ack = (wr_req && wrun >= 3) || ($urandom_range(0, 2) == 0);
            wr_err = $urandom_range(0, 1);
            rd_ack = (rd_req && rrun >= 3) || ($urandom_range(0, 2) == 0);
            rd_err = $urandom_range(0, 1);
            rd_data = $urandom;

            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            ar_f = arvalid && arready;
            b_f  = bvalid && bready;
            r_f  = rvalid && rready;
            wk   = wr_req && wr_ack;
            rk   = rd_req && rd_ack;
            wrun = (wr_req && !wk) ? wrun + 1 : 0;
            rrun = (rd_req && !rk) ? rrun + 1 : 0;

            tick;

            if (wk && awq.size() > 0 && wq.size() > 0) begin
                void'(awq.pop_front());
                void'(wq.pop_front());
                bq.push_back(wr_err ? RESP_SLVERR : RESP_OKAY);
            end
            if (rk && arq.size() > 0) begin
                void'(arq.pop_front());
                rq.push_back({rd_data, rd_err ? RESP_SLVERR : RESP_OKAY});
            end
            if (b_f && bq.size() > 0) void'(bq.pop_front());
            if (r_f && rq.size() > 0) void'(rq.pop_front());
            if (aw_f) begin awq.push_back(awaddr); awvalid = 0; end
            if (w_f) begin wq.push_back({wstrb, wdata}); wvalid = 0; end
            if (ar_f) begin arq.push_back(araddr); arvalid = 0; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
